// File: rtl/control_frecuencia_pkg.sv
// Shared definitions for the frequency-select sequencer.
// Holds the FSM state encoding, the select-code width and the default
// parameter values used by control_frecuencia and its interface.
package control_frecuencia_pkg;

  localparam int FREQ_W            = 3;
  localparam int NUM_FREQ_DEF      = 8;
  localparam int FREQ_RESET_DEF    = 0;
  localparam int TIMEOUT_DEF       = 255;
  localparam int SETTLE_CYCLES_DEF = 4;

  typedef logic [FREQ_W-1:0] freq_t;

  // FSM state encoding (kept as plain constants for legacy tooling).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_APPLY   = 2'd2;
  localparam logic [1:0] ST_SETTLE  = 2'd3;

endpackage

// File: rtl/control_frecuencia_if.sv
// Signal bundle between the button/divider environment and the sequencer.
//   Subir, Bajar        : button levels, asynchronous to the clock
//   Tick                : one-cycle pulse at the end of each divided period
//   Frecuencia_Escogida : current select code
//   Div_Reset           : one-cycle divider restart, coincident with a change
//   Ocupado             : high while the sequencer is not idle
//   Limite              : one-cycle pulse when a step is refused at min/max
//   estado              : current FSM state, for observation only
// There is no valid/ready handshake here: Subir/Bajar are levels whose
// rising edges are requests, and Tick/Div_Reset/Limite are single-cycle
// strobes that are never back-pressured.
// master drives the inputs (environment/bench), slave is the sequencer.
interface control_frecuencia_if;
  import control_frecuencia_pkg::*;

  logic  Subir;
  logic  Bajar;
  logic  Tick;
  freq_t Frecuencia_Escogida;
  logic  Div_Reset;
  logic  Ocupado;
  logic  Limite;
  logic [1:0] estado;

  modport master (
    output Subir, Bajar, Tick,
    input  Frecuencia_Escogida, Div_Reset, Ocupado, Limite, estado
  );

  modport slave (
    input  Subir, Bajar, Tick,
    output Frecuencia_Escogida, Div_Reset, Ocupado, Limite, estado
  );
endinterface

// File: rtl/control_frecuencia_sincronizador_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous level input
//   req   : one-cycle pulse for each rising edge of the synchronized level
// A rise of din before edge k makes req high in the cycle after edge k+1.
module sincronizador_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic req
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign req = sync2 & ~prev;

endmodule

// File: rtl/control_frecuencia.sv
// Frequency-select sequencer.
// Turns up/down button edges into saturating select-code steps and applies
// each change only at a divided-clock period boundary (Tick) or after a
// timeout, restarting the divider with Div_Reset so no runt pulse appears.
//   CLK   : system clock
//   Reset : asynchronous active-low reset
//   bus   : control_frecuencia_if.slave (buttons, Tick, code and status)
module control_frecuencia
  import control_frecuencia_pkg::*;
#(
  parameter int NUM_FREQ      = NUM_FREQ_DEF,
  parameter int FREQ_RESET    = FREQ_RESET_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                 CLK,
  input  logic                 Reset,
  control_frecuencia_if.slave  bus
);

  localparam freq_t      CODE_MAX    = freq_t'(NUM_FREQ - 1);
  localparam freq_t      CODE_RESET  = freq_t'(FREQ_RESET);
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic       req_up;
  logic       req_dn;
  logic [1:0] state;
  logic [1:0] next_state;
  freq_t      freq_q;
  freq_t      target_q;
  logic [7:0] cnt_to;
  logic [3:0] cnt_settle;
  logic       div_reset_q;
  logic       ocupado_q;
  logic       limite_q;

  logic       up_only;
  logic       dn_only;
  logic       up_ok;
  logic       dn_ok;
  logic       at_limit;

  sincronizador_flanco u_sinc_subir (
    .clk   (CLK),
    .rst_n (Reset),
    .din   (bus.Subir),
    .req   (req_up)
  );

  sincronizador_flanco u_sinc_bajar (
    .clk   (CLK),
    .rst_n (Reset),
    .din   (bus.Bajar),
    .req   (req_dn)
  );

  // Simultaneous up and down requests cancel each other out entirely.
  assign up_only  = req_up & ~req_dn;
  assign dn_only  = req_dn & ~req_up;
  assign up_ok    = up_only & (freq_q != CODE_MAX);
  assign dn_ok    = dn_only & (freq_q != '0);
  assign at_limit = (up_only & (freq_q == CODE_MAX)) |
                    (dn_only & (freq_q == '0));

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (up_ok || dn_ok) next_state = ST_PENDING;
      // The timeout count equals the number of cycles already spent here,
      // so the forced change leaves PENDING after TIMEOUT cycles.
      ST_PENDING: if (bus.Tick || cnt_to == TO_LAST) next_state = ST_APPLY;
      ST_APPLY:   next_state = ST_SETTLE;
      ST_SETTLE:  if (cnt_settle == SETTLE_LAST) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      freq_q      <= CODE_RESET;
      target_q    <= '0;
      cnt_to      <= '0;
      cnt_settle  <= '0;
      div_reset_q <= 1'b0;
      ocupado_q   <= 1'b0;
      limite_q    <= 1'b0;
    end else begin
      state       <= next_state;
      ocupado_q   <= (next_state != ST_IDLE);
      div_reset_q <= 1'b0;
      limite_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt_to     <= '0;
          cnt_settle <= '0;
          if (up_ok)      target_q <= freq_q + freq_t'(1);
          else if (dn_ok) target_q <= freq_q - freq_t'(1);
          limite_q <= at_limit;
        end
        ST_PENDING: begin
          if (next_state == ST_APPLY) cnt_to <= '0;
          else                        cnt_to <= cnt_to + 8'd1;
        end
        ST_APPLY: begin
          // Code and divider restart become visible together.
          freq_q      <= target_q;
          div_reset_q <= 1'b1;
        end
        ST_SETTLE: begin
          if (cnt_settle == SETTLE_LAST) cnt_settle <= '0;
          else                           cnt_settle <= cnt_settle + 4'd1;
        end
        default: begin
          cnt_to     <= '0;
          cnt_settle <= '0;
        end
      endcase
    end
  end

  assign bus.Frecuencia_Escogida = freq_q;
  assign bus.Div_Reset           = div_reset_q;
  assign bus.Ocupado             = ocupado_q;
  assign bus.Limite              = limite_q;
  assign bus.estado              = state;

endmodule

// File: tb/tb_control_frecuencia.sv
// Self-checking bench for control_frecuencia.
module tb_control_frecuencia;

  localparam int TIMEOUT = 255;

  logic CLK;
  logic Reset;

  control_frecuencia_if bus ();

  control_frecuencia dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_q[$];
  int         vectors;
  int         miscompares;
  int         model_code;
  int         divrst_cnt;
  int         limite_cnt;
  int         ocupado_cycles;
  logic [2:0] prev_code;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: every Div_Reset pulse is an output event; pop and compare code.
  always @(negedge CLK) begin
    if (Reset) begin
      if (bus.Ocupado) ocupado_cycles++;
      if (bus.Limite)  limite_cnt++;
      if (bus.Div_Reset) begin
        divrst_cnt++;
        check_val("code_change_with_div_reset",
                  32'(bus.Frecuencia_Escogida != prev_code), 32'd1);
        if (exp_q.size() == 0) begin
          check_val("unexpected_div_reset", 32'd1, 32'd0);
        end else begin
          check_val("code_after_change", 32'(bus.Frecuencia_Escogida),
                    32'(exp_q.pop_front()));
        end
      end
    end
    prev_code = bus.Frecuencia_Escogida;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b0;
    exp_q.delete();
    model_code = 0;
    cycles(3);
    Reset = 1'b1;
    cycles(2);
  endtask

  task automatic wait_ocupado(input string tag, input int budget);
    int n = 0;
    while (!bus.Ocupado && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.Ocupado) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.Ocupado && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (bus.Ocupado) check_val(tag, 32'd1, 32'd0);
  endtask

  task automatic pulse_tick();
    Tick_drive(1'b1);
    @(negedge CLK);
    Tick_drive(1'b0);
  endtask

  task automatic Tick_drive(input logic v);
    bus.Tick = v;
  endtask

  // One successful up step completed through a Tick.
  task automatic step_up();
    model_code++;
    exp_q.push_back(3'(model_code));
    bus.Subir = 1'b1;
    @(negedge CLK);
    wait_ocupado("wait_busy_step", 20);
    cycles(1);
    pulse_tick();
    bus.Subir = 1'b0;
    wait_idle("wait_idle_step", 50);
    cycles(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_lim;
    int base_div;
    int lat;
    bit seen;

    vectors = 0; miscompares = 0; model_code = 0;
    divrst_cnt = 0; limite_cnt = 0; ocupado_cycles = 0;
    bus.Subir = 1'b0; bus.Bajar = 1'b0; bus.Tick = 1'b0;
    Reset = 1'b0;
    prev_code = '0;
    #1;
    check_val("reset_code", 32'(bus.Frecuencia_Escogida), 32'd0);
    check_val("reset_ocupado", 32'(bus.Ocupado), 32'd0);
    check_val("reset_div_reset", 32'(bus.Div_Reset), 32'd0);
    check_val("reset_limite", 32'(bus.Limite), 32'd0);
    check_val("reset_state", 32'(bus.estado), 32'd0);
    cycles(3);
    Reset = 1'b1;

    // 1. idle after reset release, random Tick noise is ignored in IDLE
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      bus.Tick = 1'($urandom_range(0, 1));
    end
    bus.Tick = 1'b0;
    cycles(2);
    check_val("idle_code", 32'(bus.Frecuencia_Escogida), 32'd0);
    check_val("idle_busy_cycles", 32'(ocupado_cycles), 32'd0);
    check_val("idle_div_resets", 32'(divrst_cnt), 32'd0);
    check_val("idle_limites", 32'(limite_cnt), 32'd0);

    // 3a. Bajar at code 0 -> one Limite, nothing else
    bus.Bajar = 1'b1;
    cycles(10);
    bus.Bajar = 1'b0;
    cycles(10);
    check_val("bajar_min_limite", 32'(limite_cnt), 32'd1);
    check_val("bajar_min_code", 32'(bus.Frecuencia_Escogida), 32'd0);
    check_val("bajar_min_busy", 32'(ocupado_cycles), 32'd0);

    // 2. Subir held 10 cycles, Tick 5 cycles after Ocupado rises
    ocupado_cycles = 0;
    base_div = divrst_cnt;
    model_code = 1;
    exp_q.push_back(3'd1);
    bus.Subir = 1'b1;
    wait_ocupado("wait_busy_t2", 20);
    lat = 0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      lat++;
    end
    bus.Tick = 1'b1;
    while (!seen && lat < 30) begin
      @(negedge CLK);
      lat++;
      bus.Tick = 1'b0;
      if (bus.Div_Reset) seen = 1'b1;
    end
    check_val("tick_change_latency", 32'(lat), 32'd7);
    bus.Subir = 1'b0;
    wait_idle("wait_idle_t2", 50);
    cycles(5);
    check_val("t2_busy_cycles", 32'(ocupado_cycles), 32'd11);
    check_val("t2_div_reset_count", 32'(divrst_cnt - base_div), 32'd1);
    check_val("t2_code", 32'(bus.Frecuencia_Escogida), 32'd1);

    // 3b. six more steps to the top, then one refused Subir
    for (int i = 0; i < 6; i++) step_up();
    check_val("top_code", 32'(bus.Frecuencia_Escogida), 32'd7);
    base_lim = limite_cnt;
    base_div = divrst_cnt;
    ocupado_cycles = 0;
    bus.Subir = 1'b1;
    cycles(10);
    bus.Subir = 1'b0;
    cycles(10);
    check_val("subir_max_limite", 32'(limite_cnt - base_lim), 32'd1);
    check_val("subir_max_code", 32'(bus.Frecuencia_Escogida), 32'd7);
    check_val("subir_max_busy", 32'(ocupado_cycles), 32'd0);
    check_val("subir_max_div_reset", 32'(divrst_cnt - base_div), 32'd0);

    // 4. timeout path: Subir from 0 with Tick held low
    do_reset();
    base_div = divrst_cnt;
    model_code = 1;
    exp_q.push_back(3'd1);
    bus.Subir = 1'b1;
    wait_ocupado("wait_busy_t4", 20);
    bus.Subir = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < TIMEOUT + 40) begin
      @(negedge CLK);
      lat++;
      if (bus.Div_Reset) seen = 1'b1;
    end
    check_val("timeout_seen", 32'(seen), 32'd1);
    check_val("timeout_latency_window",
              32'(lat >= TIMEOUT && lat <= TIMEOUT + 2), 32'd1);
    wait_idle("wait_idle_t4", 20);
    cycles(3);
    check_val("timeout_div_reset_count", 32'(divrst_cnt - base_div), 32'd1);
    check_val("timeout_code", 32'(bus.Frecuencia_Escogida), 32'd1);

    // 5a. Subir and Bajar together -> ignored
    base_lim = limite_cnt;
    ocupado_cycles = 0;
    bus.Subir = 1'b1;
    bus.Bajar = 1'b1;
    cycles(10);
    bus.Subir = 1'b0;
    bus.Bajar = 1'b0;
    cycles(10);
    check_val("both_limite", 32'(limite_cnt - base_lim), 32'd0);
    check_val("both_busy", 32'(ocupado_cycles), 32'd0);
    check_val("both_code", 32'(bus.Frecuencia_Escogida), 32'd1);

    // 5b. second Subir edge during PENDING is dropped
    base_div = divrst_cnt;
    model_code = 2;
    exp_q.push_back(3'd2);
    bus.Subir = 1'b1;
    wait_ocupado("wait_busy_t5", 20);
    bus.Subir = 1'b0;
    cycles(2);
    bus.Subir = 1'b1;
    cycles(4);
    bus.Subir = 1'b0;
    cycles(2);
    pulse_tick();
    wait_idle("wait_idle_t5", 50);
    cycles(20);
    check_val("drop_div_reset_count", 32'(divrst_cnt - base_div), 32'd1);
    check_val("drop_code", 32'(bus.Frecuencia_Escogida), 32'd2);
    check_val("drop_limite", 32'(limite_cnt - base_lim), 32'd0);

    // 6. reset while PENDING 2 -> 3
    bus.Subir = 1'b1;
    wait_ocupado("wait_busy_t6", 20);
    bus.Subir = 1'b0;
    cycles(2);
    check_val("t6_pending_state", 32'(bus.estado), 32'd1);
    base_div = divrst_cnt;
    Reset = 1'b0;
    #1;
    check_val("async_reset_code", 32'(bus.Frecuencia_Escogida), 32'd0);
    check_val("async_reset_busy", 32'(bus.Ocupado), 32'd0);
    exp_q.delete();
    model_code = 0;
    cycles(3);
    Reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      bus.Tick = 1'($urandom_range(0, 1));
    end
    bus.Tick = 1'b0;
    cycles(2);
    check_val("post_reset_div_reset", 32'(divrst_cnt - base_div), 32'd0);
    check_val("post_reset_code", 32'(bus.Frecuencia_Escogida), 32'd0);

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/control_frecuencia.md
Name: control_frecuencia

Overview:
Sequences the frequency-select code (Frecuencia_Escogida) that feeds the frequency-division datapath (select-code decoder plus clock divider). Converts asynchronous up/down button levels into saturating select-code steps. Each change is applied only at a divided-clock period boundary, signalled by Tick, or after a timeout, so DivCLK never produces a runt pulse. Issues a one-cycle restart pulse to the divider on every change.

Parameters:
NUM_FREQ, 8, number of valid select codes; legal range 2..8; codes 0..NUM_FREQ-1.
FREQ_RESET, 0, select code after reset; must be < NUM_FREQ.
TIMEOUT, 255, cycles to wait in PENDING for Tick before forcing the change; 8-bit counter; legal range 1..255.
SETTLE_CYCLES, 4, cycles spent in SETTLE after a change; legal range 1..15.

Ports:
CLK  in  1  system clock.
Reset  in  1  asynchronous, active-low reset.
Subir  in  1  "frequency up" button level; asynchronous to CLK.
Bajar  in  1  "frequency down" button level; asynchronous to CLK.
Tick  in  1  one-cycle pulse from the divider at the end of each DivCLK period.
Frecuencia_Escogida  out  3  select code to the divider path.
Div_Reset  out  1  one-cycle pulse that restarts the divider counter.
Ocupado  out  1  high whenever the FSM is not in IDLE.
Limite  out  1  one-cycle pulse when a request is rejected at the min or max code.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, Frecuencia_Escogida=FREQ_RESET, Div_Reset=0, Ocupado=0, Limite=0.
  - Timeout/settle counters, target register and all synchronizer flops cleared.
- All outputs are registered.
- Input conditioning, per button:
  - Two-flop synchronizer, then a previous-value flop.
  - req = sync2 & ~prev, a single-cycle request per rising edge.
  - Input rising before edge k gives req high in the cycle after edge k+1; the FSM acts on it at edge k+2.
- Simultaneous requests: req_up and req_dn high in the same cycle -> both discarded, no Limite pulse.
- IDLE:
  - req_up with Frecuencia_Escogida < NUM_FREQ-1 -> target = code+1, go PENDING.
  - req_dn with code > 0 -> target = code-1, go PENDING.
  - req_up at NUM_FREQ-1, or req_dn at 0 -> Limite=1 for one cycle, stay in IDLE.
  - Codes saturate; no wrap-around.
- PENDING:
  - Timeout counter increments every cycle.
  - Tick=1, or counter reaching TIMEOUT -> go APPLY and clear the counter.
  - Tick is ignored in every other state.
- APPLY, one cycle:
  - At exit, Frecuencia_Escogida <= target and Div_Reset <= 1.
  - Both become visible in the same cycle, which is the first SETTLE cycle.
  - Then go SETTLE.
- SETTLE:
  - Div_Reset returns to 0 after one cycle.
  - Counts SETTLE_CYCLES cycles, then returns to IDLE.
- Ocupado is registered from the next-state value, so it is high exactly while state != IDLE.
- Request dropping: requests arriving while not in IDLE are dropped. They are not queued and produce no Limite pulse.
- Change latency: Tick arriving n cycles after entering PENDING gives a code change n+2 edges after PENDING entry. Minimum is 2, when Tick arrives on the first PENDING cycle.
- Reset asserted mid-operation aborts any pending change; all state returns to reset values.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, PENDING=2'd1, APPLY=2'd2, SETTLE=2'd3.
  - FREQ_W=3.
  - Default values of NUM_FREQ, TIMEOUT and SETTLE_CYCLES.
- One sub-module, sincronizador_flanco: 2-flop synchronizer plus rising-edge detect, async active-low reset. Instantiated twice, for Subir and Bajar.

Test Plan:
1. Reset release, no stimulus -> Frecuencia_Escogida=0, Div_Reset=0, Ocupado=0, Limite=0 for 50 cycles.
2. Subir pulse (held 10 cycles) from code 0, Tick given 5 cycles after Ocupado rises -> code becomes 1; exactly one Div_Reset pulse, coincident with the code change; Ocupado high for 1+5+1+4 cycles.
3. Bajar at code 0 -> Limite pulses once, code stays 0, Ocupado stays 0; after seven successful Subir steps, code=7; one further Subir -> Limite pulse, code stays 7.
4. Subir with Tick held at 0 -> code changes after the TIMEOUT=255 wait, with Div_Reset pulsing once.
5. Subir and Bajar rising in the same cycle -> no state change, no Limite pulse. A second Subir edge issued during PENDING is dropped, so only a single +1 step occurs.
6. Reset asserted in PENDING with target=3 from code 2 -> code returns to 0 immediately (asynchronous); no Div_Reset pulse after release.
